// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a multiplexed 7-segment display bus: each digit's
// pattern must be stable for STABLE_CNT valid samples before it is committed.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CNT     = 3,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    commit,
  output logic                    frame_valid
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int SW = NUM_DIGITS + 7;

  typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           last_q, last_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    commit_q, commit_d;
  logic                    frame_q, frame_d;

  logic [6:0]            seg_v;
  logic [SW-1:0]         samp;
  logic                  onehot;
  logic                  same;
  logic [CW-1:0]         cnt_inc;
  logic                  do_commit;
  logic [4:0]            dec;
  logic [NUM_DIGITS-1:0] seen_nx;

  // Returns {miss, nibble}; patterns outside the table decode as 0 with miss set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h7E: r = 5'h00;  7'h30: r = 5'h01;  7'h6D: r = 5'h02;  7'h79: r = 5'h03;
      7'h33: r = 5'h04;  7'h5B: r = 5'h05;  7'h5F: r = 5'h06;  7'h70: r = 5'h07;
      7'h7F: r = 5'h08;  7'h7B: r = 5'h09;  7'h77: r = 5'h0A;  7'h1F: r = 5'h0B;
      7'h4E: r = 5'h0C;  7'h3D: r = 5'h0D;  7'h4F: r = 5'h0E;  7'h47: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign seg_v   = (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
  assign samp    = {dig_sel, seg_v};
  assign onehot  = ($countones(dig_sel) == 1);
  assign same    = (samp == last_q);
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    do_commit = 1'b0;
    if (sample_en && !onehot) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (sample_en) begin
      case (state_q)
        IDLE: begin
          last_d = samp;
          cnt_d  = CW'(1);
          if (STABLE_CNT == 1) begin
            do_commit = 1'b1;
            state_d   = LOCK;
          end else begin
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (same) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(STABLE_CNT)) begin
              do_commit = 1'b1;
              state_d   = LOCK;
            end
          end else begin
            last_d = samp;
            cnt_d  = CW'(1);
          end
        end
        LOCK: begin
          if (!same) begin
            last_d = samp;
            cnt_d  = CW'(1);
            if (STABLE_CNT == 1) do_commit = 1'b1;
            else                 state_d   = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hex_d    = hex_q;
    err_d    = err_q;
    seen_d   = seen_q;
    commit_d = 1'b0;
    frame_d  = 1'b0;
    dec      = decode(seg_v);
    seen_nx  = seen_q | dig_sel;
    if (do_commit) begin
      commit_d = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (dig_sel[i]) begin
          hex_d[4*i +: 4] = dec[3:0];
          err_d[i]        = dec[4];
        end
      end
      // Completing the mask ends the frame and starts the next one empty.
      if (&seen_nx) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d = seen_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      seen_q   <= '0;
      err_q    <= '0;
      hex_q    <= '0;
      commit_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      hex_q    <= hex_d;
      commit_q <= commit_d;
      frame_q  <= frame_d;
    end
  end

  assign hex_out     = hex_q;
  assign digit_err   = err_q;
  assign commit      = commit_q;
  assign frame_valid = frame_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: expected commits are queued as samples
// are driven and checked against hex_out/digit_err when commit is seen.
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic        sample_en;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] hex_out;
  logic [3:0]  digit_err;
  logic        commit;
  logic        frame_valid;

  int checks   = 0;
  int failures = 0;

  // Entry: {digit[2:0], err, nibble[3:0]}
  logic [7:0] exp_q[$];

  logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  seg7_scan_decoder #(
    .NUM_DIGITS(4),
    .STABLE_CNT(3),
    .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_en(sample_en),
    .seg_in(seg_in),
    .dig_sel(dig_sel),
    .hex_out(hex_out),
    .digit_err(digit_err),
    .commit(commit),
    .frame_valid(frame_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample, clock it in, then check the registered outputs.
  task automatic step(input logic en, input logic [3:0] sel, input logic [6:0] seg,
                      input logic exp_c, input logic exp_f,
                      input logic [3:0] nib, input logic err);
    logic [7:0] e;
    int d = 0;
    sample_en = en;
    dig_sel   = sel;
    seg_in    = seg;
    if (exp_c) begin
      for (int i = 0; i < 4; i++) if (sel[i]) d = i;
      exp_q.push_back({3'(d), err, nib});
    end
    @(posedge clk);
    #1;
    chk("commit", 32'(commit), 32'(exp_c));
    chk("frame_valid", 32'(frame_valid), 32'(exp_f));
    if (commit === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hex_nibble", 32'(hex_out[4*int'(e[7:5]) +: 4]), 32'(e[3:0]));
      chk("digit_err_bit", 32'(digit_err[int'(e[7:5])]), 32'(e[4]));
    end
  endtask

  task automatic go_idle();
    step(1'b1, 4'b0000, 7'h00, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    sample_en = 1'b0;
    seg_in    = '0;
    dig_sel   = '0;
    #1;
    chk("reset_hex", 32'(hex_out), 32'h0);
    chk("reset_err", 32'(digit_err), 32'h0);
    chk("reset_commit", 32'(commit), 32'h0);
    chk("reset_frame", 32'(frame_valid), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stability: three identical samples commit on the third edge.
    step(1'b1, 4'b0001, 7'h6D, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0001, 7'h6D, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0001, 7'h6D, 1'b1, 1'b0, 4'h2, 1'b0);
    step(1'b1, 4'b0001, 7'h6D, 1'b0, 1'b0, 4'h0, 1'b0);
    go_idle();
    step(1'b1, 4'b0001, 7'h6D, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0001, 7'h6D, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0001, 7'h30, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0001, 7'h30, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0001, 7'h30, 1'b1, 1'b0, 4'h1, 1'b0);

    // Full table on digit 0, then an unknown pattern and recovery.
    for (int k = 0; k < 16; k++) begin
      go_idle();
      step(1'b1, 4'b0001, pat[k], 1'b0, 1'b0, 4'h0, 1'b0);
      step(1'b1, 4'b0001, pat[k], 1'b0, 1'b0, 4'h0, 1'b0);
      step(1'b1, 4'b0001, pat[k], 1'b1, 1'b0, 4'(k), 1'b0);
    end
    for (int r = 0; r < 3; r++)
      step(1'b1, 4'b0001, 7'h00, r == 2, 1'b0, 4'h0, 1'b1);
    chk("err_set", 32'(digit_err), 32'h1);
    for (int r = 0; r < 3; r++)
      step(1'b1, 4'b0001, 7'h7E, r == 2, 1'b0, 4'h0, 1'b0);
    chk("err_cleared", 32'(digit_err), 32'h0);

    // Frame: digits 0..3 show 1..4; frame_valid with digit 3's commit.
    go_idle();
    for (int dg = 0; dg < 4; dg++)
      for (int r = 0; r < 3; r++)
        step(1'b1, 4'(1 << dg), pat[dg+1], r == 2, (r == 2) && (dg == 3), 4'(dg + 1), 1'b0);
    chk("frame_hex", 32'(hex_out), 32'h4321);
    chk("frame_err", 32'(digit_err), 32'h0);

    // Glitch: multi-hot select restarts the count.
    step(1'b1, 4'b0010, pat[5], 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0010, pat[5], 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0011, pat[5], 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0010, pat[5], 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0010, pat[5], 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0010, pat[5], 1'b1, 1'b0, 4'h5, 1'b0);

    // Hold: sample_en low freezes the count; steady LOCK commits once.
    step(1'b1, 4'b0100, pat[6], 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0100, pat[6], 1'b0, 1'b0, 4'h0, 1'b0);
    for (int h = 0; h < 10; h++)
      step(1'b0, 4'(h), 7'($urandom_range(0, 127)), 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b0100, pat[6], 1'b1, 1'b0, 4'h6, 1'b0);
    for (int h = 0; h < 5; h++)
      step(1'b1, 4'b0100, pat[6], 1'b0, 1'b0, 4'h0, 1'b0);
    chk("hold_hex", 32'(hex_out), 32'h4651);

    // Async reset mid-TRACK: everything clears and the count starts over.
    step(1'b1, 4'b1000, pat[7], 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b1000, pat[7], 1'b0, 1'b0, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_hex", 32'(hex_out), 32'h0);
    chk("midreset_err", 32'(digit_err), 32'h0);
    chk("midreset_commit", 32'(commit), 32'h0);
    chk("midreset_frame", 32'(frame_valid), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'b1000, pat[7], 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b1000, pat[7], 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 4'b1000, pat[7], 1'b1, 1'b0, 4'h7, 1'b0);
    chk("post_reset_hex", 32'(hex_out), 32'h7000);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
